// File: rtl/intr_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
// Holds the FSM state enum, default port IDs and the priority encoder.
package intr_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ASSERT,
      SERVICE
   } state_t;

   localparam logic [7:0] ID_MASK_D = 8'h30;
   localparam logic [7:0] ID_PEND_D = 8'h31;
   localparam logic [7:0] ID_VEC_D  = 8'h32;
   localparam logic [7:0] ID_EOI_D  = 8'h33;

   // Index of the lowest set bit; 0 when nothing is set.
   function automatic logic [2:0] prio_enc(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// MCU OUT/IN port bus as seen by the interrupt controller.
// master = MCU side, slave = controller side.
interface intr_ctrl_if;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       io_strb;
   logic [7:0] rd_data;
   logic       rd_hit;

   modport master (
      output port_id,
      output out_port,
      output io_strb,
      input  rd_data,
      input  rd_hit
   );

   modport slave (
      input  port_id,
      input  out_port,
      input  io_strb,
      output rd_data,
      output rd_hit
   );
endinterface

// File: rtl/intr_ctrl_sync_edge.sv
// Three-flop synchronizer for one request line.
// Emits a one-cycle pulse on a synchronized rising edge.
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic pulse
);

   logic s1, s2, s3;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign pulse = s2 & ~s3;

endmodule

// File: rtl/intr_ctrl.sv
// Multi-source interrupt controller with mask, pending and fixed priority.
// Single irq line with ACK/EOI handshake over the MCU port bus.
module intr_ctrl
   import intr_pkg::*;
#(
   parameter int         NUM_SRC = 8,
   parameter logic [7:0] ID_MASK = ID_MASK_D,
   parameter logic [7:0] ID_PEND = ID_PEND_D,
   parameter logic [7:0] ID_VEC  = ID_VEC_D,
   parameter logic [7:0] ID_EOI  = ID_EOI_D
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] src,
   intr_ctrl_if.slave         bus,
   output logic               irq
);

   localparam logic [7:0] SRC_MSK =
      8'((16'd1 << NUM_SRC) - 16'd1);

   logic [NUM_SRC-1:0] rise;
   logic [7:0]         rise8;
   logic [7:0]         mask;
   logic [7:0]         pend;
   logic [7:0]         active;
   logic [7:0]         clr;
   logic [2:0]         cur_id;
   state_t             state;

   logic wr_mask, wr_pend, wr_vec, wr_eoi;
   logic ack, eoi;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
      sync_edge u_sync (
         .clk   (clk),
         .reset (reset),
         .d     (src[i]),
         .pulse (rise[i])
      );
   end

   assign rise8   = 8'(rise);
   assign wr_mask = bus.io_strb && (bus.port_id == ID_MASK);
   assign wr_pend = bus.io_strb && (bus.port_id == ID_PEND);
   assign wr_vec  = bus.io_strb && (bus.port_id == ID_VEC);
   assign wr_eoi  = bus.io_strb && (bus.port_id == ID_EOI);
   assign ack     = wr_vec && (state == ASSERT);
   assign eoi     = wr_eoi && (state == SERVICE);
   assign active  = pend & mask;

   always_comb begin
      clr = 8'h00;
      if (wr_pend) clr = clr | bus.out_port;
      if (ack)     clr = clr | (8'h01 << cur_id);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask <= 8'h00;
         pend <= 8'h00;
      end else begin
         if (wr_mask) mask <= bus.out_port & SRC_MSK;
         // a new edge beats a clear in the same cycle
         pend <= (pend & ~clr) | rise8;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cur_id <= 3'd0;
         irq    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (active != 8'h00) begin
                  cur_id <= prio_enc(active);
                  state  <= ASSERT;
                  irq    <= 1'b1;
               end
            end
            ASSERT: begin
               if (ack) begin
                  state <= SERVICE;
                  irq   <= 1'b0;
               end else if (!mask[cur_id]) begin
                  state <= IDLE;
                  irq   <= 1'b0;
               end
            end
            SERVICE: begin
               if (eoi) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               irq   <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      bus.rd_data = 8'h00;
      bus.rd_hit  = 1'b1;
      unique case (1'b1)
         (bus.port_id == ID_MASK): bus.rd_data = mask;
         (bus.port_id == ID_PEND): bus.rd_data = pend;
         (bus.port_id == ID_VEC):  bus.rd_data = {state == ASSERT,
                                                  state == SERVICE,
                                                  3'b000, cur_id};
         (bus.port_id == ID_EOI):  bus.rd_data = 8'h00;
         default:                  bus.rd_hit  = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: behavioural model plus directed
// scenarios and a randomized phase.
module tb_intr_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] src = 8'h00;
   logic       irq;

   intr_ctrl_if bus ();

   intr_ctrl #(.NUM_SRC(8)) dut (
      .clk   (clk),
      .reset (reset),
      .src   (src),
      .bus   (bus),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // model: 0 idle, 1 asserting, 2 in service
   logic [7:0] m_mask, m_pend;
   logic [7:0] h0, h1, h2;
   int         m_st, m_cur;

   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] m_read(logic [7:0] id);
      case (id)
         8'h30:   return m_mask;
         8'h31:   return m_pend;
         8'h32:   return {m_st == 1, m_st == 2, 3'b000, 3'(m_cur)};
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] other_id();
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      if (v >= 8'h30 && v <= 8'h33) v = v + 8'h10;
      return v;
   endfunction

   task automatic model_reset();
      m_mask = 0; m_pend = 0;
      h0 = 0; h1 = 0; h2 = 0;
      m_st = 0; m_cur = 0;
   endtask

   // advance model by one clock edge using the inputs now present
   task automatic model_step();
      logic [7:0] rise, clr, act;
      logic       st, ack, eoi;
      logic [7:0] pid;
      if (!reset) begin
         model_reset();
         return;
      end
      pid  = bus.port_id;
      st   = bus.io_strb;
      rise = h1 & ~h2;
      ack  = st && pid == 8'h32 && m_st == 1;
      eoi  = st && pid == 8'h33 && m_st == 2;
      clr  = 0;
      if (st && pid == 8'h31) clr = bus.out_port;
      if (ack) clr[m_cur] = 1'b1;
      act = m_pend & m_mask;
      case (m_st)
         0: if (act != 0) begin
            for (int i = 7; i >= 0; i--) if (act[i]) m_cur = i;
            m_st = 1;
         end
         1: if (ack) m_st = 2;
            else if (!m_mask[m_cur]) m_st = 0;
         default: if (eoi) m_st = 0;
      endcase
      m_pend = (m_pend & ~clr) | rise;
      if (st && pid == 8'h30) m_mask = bus.out_port;
      h2 = h1; h1 = h0; h0 = src;
   endtask

   task automatic check_all();
      logic [7:0] save, id;
      logic [7:0] ids [5];
      save = bus.port_id;
      ids = '{8'h30, 8'h31, 8'h32, 8'h33, other_id()};
      chk("irq", 8'(irq), 8'(m_st == 1));
      for (int i = 0; i < 5; i++) begin
         id = ids[i];
         bus.port_id = id;
         #1;
         chk($sformatf("rd_%02h", id), bus.rd_data, m_read(id));
         chk($sformatf("hit_%02h", id), 8'(bus.rd_hit),
             8'(i < 4));
      end
      bus.port_id = save;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic steps(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(logic [7:0] id, logic [7:0] d);
      bus.port_id  = id;
      bus.out_port = d;
      bus.io_strb  = 1'b1;
      step();
      bus.io_strb  = 1'b0;
      bus.port_id  = other_id();
   endtask

   task automatic chk_rd(string nm, logic [7:0] id, logic [7:0] exp);
      logic [7:0] save;
      save = bus.port_id;
      bus.port_id = id;
      #1;
      chk(nm, bus.rd_data, exp);
      bus.port_id = save;
   endtask

   initial begin
      bus.port_id  = 8'h00;
      bus.out_port = 8'h00;
      bus.io_strb  = 1'b0;
      model_reset();

      // reset held with all sources high
      src = 8'hFF;
      steps(3);
      chk("rst_irq", 8'(irq), 8'h00);
      chk_rd("rst_mask", 8'h30, 8'h00);
      chk_rd("rst_pend", 8'h31, 8'h00);
      reset = 1'b1;
      steps(4);
      chk_rd("rel_pend", 8'h31, 8'hFF);
      chk("rel_irq", 8'(irq), 8'h00);
      src = 8'h00;
      wr(8'h31, 8'hFF);

      // latency and handshake
      wr(8'h30, 8'h04);
      src = 8'h04;
      step();
      src = 8'h00;
      step();
      chk_rd("lat_e2", 8'h31, 8'h00);
      step();
      chk_rd("lat_e3", 8'h31, 8'h04);
      chk("lat_irq3", 8'(irq), 8'h00);
      step();
      chk("lat_irq4", 8'(irq), 8'h01);
      chk_rd("lat_vec", 8'h32, 8'h82);
      wr(8'h32, 8'h00);
      chk("ack_irq", 8'(irq), 8'h00);
      chk_rd("ack_pend", 8'h31, 8'h00);
      chk_rd("ack_vec", 8'h32, 8'h42);
      wr(8'h32, 8'h00);
      chk_rd("ack2_vec", 8'h32, 8'h42);
      wr(8'h33, 8'h00);
      chk_rd("eoi_vec", 8'h32, 8'h02);

      // priority without preemption
      wr(8'h30, 8'hFF);
      src = 8'h20;
      steps(4);
      chk_rd("pri_vec5", 8'h32, 8'h85);
      src = 8'h22;
      steps(5);
      chk_rd("pri_nopre", 8'h32, 8'h85);
      src = 8'h00;
      wr(8'h32, 8'h00);
      wr(8'h33, 8'h00);
      chk("pri_gap", 8'(irq), 8'h00);
      step();
      chk("pri_re", 8'(irq), 8'h01);
      chk_rd("pri_vec1", 8'h32, 8'h81);
      wr(8'h32, 8'h00);
      wr(8'h33, 8'h00);
      step();

      // mask-out while asserting
      src = 8'h08;
      steps(4);
      chk_rd("mo_vec", 8'h32, 8'h83);
      src = 8'h00;
      wr(8'h30, 8'h00);
      step();
      chk("mo_irq", 8'(irq), 8'h00);
      chk_rd("mo_pend", 8'h31, 8'h08);
      wr(8'h30, 8'h08);
      step();
      chk("mo_re", 8'(irq), 8'h01);
      wr(8'h32, 8'h00);
      wr(8'h33, 8'h00);

      // set/clear collision
      wr(8'h30, 8'h00);
      src = 8'h01;
      steps(2);
      wr(8'h31, 8'h01);
      chk_rd("col_set", 8'h31, 8'h01);
      src = 8'h10;
      steps(4);
      chk_rd("col_11", 8'h31, 8'h11);
      wr(8'h31, 8'h10);
      chk_rd("col_clr", 8'h31, 8'h01);
      src = 8'h00;
      wr(8'h31, 8'hFF);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) src = 8'($urandom);
         case ($urandom_range(0, 11))
            0:       wr(8'h30, 8'($urandom));
            1:       wr(8'h31, 8'($urandom));
            2, 3:    wr(8'h32, 8'($urandom));
            4, 5:    wr(8'h33, 8'($urandom));
            6:       wr(other_id(), 8'($urandom));
            default: step();
         endcase
      end

      // reset in the middle of a service
      src = 8'h00;
      steps(4);
      wr(8'h31, 8'hFF);
      wr(8'h30, 8'hFF);
      while (irq) begin
         wr(8'h32, 8'h00);
         wr(8'h33, 8'h00);
         wr(8'h31, 8'hFF);
      end
      src = 8'h40;
      steps(4);
      wr(8'h32, 8'h00);
      reset = 1'b0;
      #1;
      chk("mid_irq", 8'(irq), 8'h00);
      chk_rd("mid_vec", 8'h32, 8'h00);
      chk_rd("mid_mask", 8'h30, 8'h00);
      steps(2);
      reset = 1'b1;
      steps(3);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
